decoder_onehot_pipe: RTL and testbench
======================================

Name: decoder_onehot_pipe

Overview:
Parametrised, registered successor to the team's fixed 3-to-8 one-hot decoder. It adds a valid/ready handshake on input and output, a one-cycle pipeline register, and three decode modes: one-hot, thermometer, and sticky accumulate mask with clear. It sits between the control/decode stage and register-file or bank write-enable logic where select vectors must be timed and back-pressured.

Parameters:
IN_WIDTH, 3, width of index input.
OUT_WIDTH, 8, width of decoded vector; legal range 2..2**IN_WIDTH; indices >= OUT_WIDTH are out of range.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst_n  input  1  synchronous reset, active low.
in_valid  input  1  request present.
in_ready  output  1  block can accept request this cycle.
in_idx  input  IN_WIDTH  index to decode.
mode  input  2  00 one-hot, 01 thermometer, 10 accumulate, 11 clear mask; sampled with request.
out_valid  output  1  f/err hold a result.
out_ready  input  1  consumer accepts result.
f  output  OUT_WIDTH  decoded vector (registered).
err  output  1  result came from out-of-range index (registered).
acc_full  output  1  accumulate mask is all ones (registered, reflects mask after last update).

Behaviour:
- Reset (rst_n=0 at clk edge): out_valid=0, f=0, err=0, acc_full=0, internal mask acc=0; overrides any handshake in the same cycle.
- in_ready = !out_valid || out_ready (combinational, no dependence on in_valid).
- Accept = in_valid && in_ready. On accept: output register loads result, out_valid=1 next cycle. Latency 1 cycle.
- No accept and out_ready && out_valid: out_valid->0; f, err, acc_full hold last values.
- Stall (out_valid && !out_ready): f, err, out_valid stable; in_ready=0; input ignored.
- Simultaneous pop and accept: new result replaces old with no bubble; full throughput 1/cycle.
- Mode 00 one-hot: f bit in_idx = 1, others 0. Out of range: f=0, err=1.
- Mode 01 thermometer: f bits [in_idx:0] = 1 (idx 0 -> 0x01, idx 7 -> 0xFF at 8 bits). Out of range: f=all ones, err=1.
- Mode 10 accumulate: acc_next = acc | onehot(in_idx); f = acc_next; acc updated. Out of range: acc unchanged, f=acc, err=1.
- Mode 11 clear: acc=0, f=0, err=0; in_idx ignored.
- err=0 for every in-range result.
- acc only changes on accepted mode 10/11 requests. It is unaffected by modes 00/01 and by stalls.
- acc_full updates on every accept to (acc_next == all ones).
- No state machine beyond the output register and acc; no combinational path from in_* to f/err.

Test Plan:
- Reset, then stream idx 0..7 in mode 00 with out_ready=1: f = 0x01,0x02,...,0x80 on consecutive cycles 1 cycle after each accept; err=0; in_ready constantly 1.
- Mode 01 with idx=3 -> f=0x0F; idx=0 -> f=0x01. With IN_WIDTH=3, OUT_WIDTH=6, idx=7 -> f=0x3F, err=1; same idx in mode 00 -> f=0x00, err=1.
- Mode 10 with idx 1, 4, 1, then 0,2,3,5,6,7 -> f=0x02,0x12,0x12,...,0xFF. acc_full rises only with final result. Then mode 11 -> f=0x00, acc_full=0. Next mode 10 idx 2 -> f=0x04.
- Back-pressure: out_ready=0 for 3 cycles after first result 0x08. Require f=0x08 and out_valid=1 held, in_ready=0, and pending idx=5 not accepted until out_ready=1, then f=0x20 next cycle.
- Reset mid-stream: drive rst_n=0 with out_valid=1, acc=0x12, out_ready=0. Next cycle out_valid=0, f=0, acc cleared, so mode 10 idx 0 -> f=0x01.

Source files
------------

// File: rtl/decoder_onehot_pipe.sv
// Registered index decoder with valid/ready handshake on both sides.
// Decodes an index into a one-hot or thermometer vector, or folds it into a
// sticky accumulate mask that can be cleared. Results sit in a single output
// register that back-pressures the producer while the consumer stalls.
module decoder_onehot_pipe #(
  parameter int unsigned IN_WIDTH  = 3,
  parameter int unsigned OUT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  in_idx,
  input  logic [1:0]           mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] f,
  output logic                 err,
  output logic                 acc_full
);

  typedef enum logic [1:0] {
    ModeOnehot = 2'b00,
    ModeThermo = 2'b01,
    ModeAccum  = 2'b10,
    ModeClear  = 2'b11
  } mode_e;

  // One extra bit so OUT_WIDTH == 2**IN_WIDTH is representable as a limit.
  localparam int unsigned          IdxW     = IN_WIDTH + 1;
  localparam logic [IdxW-1:0]      OutLimit = IdxW'(OUT_WIDTH);
  localparam logic [OUT_WIDTH-1:0] AllOnes  = '1;

  logic                 out_valid_q, out_valid_d;
  logic [OUT_WIDTH-1:0] f_q, f_d;
  logic                 err_q, err_d;
  logic                 acc_full_q, acc_full_d;
  logic [OUT_WIDTH-1:0] acc_q, acc_d;

  logic                 accept;
  logic [IdxW-1:0]      idx_ext;
  logic                 in_range;
  logic [OUT_WIDTH-1:0] onehot_vec;
  logic [OUT_WIDTH-1:0] thermo_vec;
  mode_e                mode_sel;

  // Output register free, or being drained this cycle: both allow a new result.
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign mode_sel = mode_e'(mode);

  // Raw decode of the index; out-of-range indices naturally yield all-zero
  // one-hot and all-ones thermometer vectors, which is the required result.
  always_comb begin
    idx_ext    = {1'b0, in_idx};
    in_range   = idx_ext < OutLimit;
    onehot_vec = '0;
    thermo_vec = '0;
    for (int i = 0; i < int'(OUT_WIDTH); i++) begin
      onehot_vec[i] = (idx_ext == IdxW'(i));
      thermo_vec[i] = (idx_ext >= IdxW'(i));
    end
  end

  // Next-state for output register and accumulate mask.
  always_comb begin
    out_valid_d = out_valid_q;
    f_d         = f_q;
    err_d       = err_q;
    acc_full_d  = acc_full_q;
    acc_d       = acc_q;

    if (accept) begin
      out_valid_d = 1'b1;
      unique case (mode_sel)
        ModeOnehot: begin
          f_d   = onehot_vec;
          err_d = !in_range;
        end
        ModeThermo: begin
          f_d   = thermo_vec;
          err_d = !in_range;
        end
        ModeAccum: begin
          if (in_range) begin
            acc_d = acc_q | onehot_vec;
          end
          f_d   = acc_d;
          err_d = !in_range;
        end
        ModeClear: begin
          acc_d = '0;
          f_d   = '0;
          err_d = 1'b0;
        end
      endcase
      // Tracks the mask as it stands after this request, whatever the mode.
      acc_full_d = (acc_d == AllOnes);
    end else if (out_ready) begin
      // Result consumed with nothing to replace it; data fields hold.
      out_valid_d = 1'b0;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      f_q         <= '0;
      err_q       <= 1'b0;
      acc_full_q  <= 1'b0;
      acc_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      f_q         <= f_d;
      err_q       <= err_d;
      acc_full_q  <= acc_full_d;
      acc_q       <= acc_d;
    end
  end

  assign out_valid = out_valid_q;
  assign f         = f_q;
  assign err       = err_q;
  assign acc_full  = acc_full_q;

endmodule

// File: tb/tb_decoder_onehot_pipe.sv
// Directed bench for decoder_onehot_pipe: an 8-output instance for the main
// handshake/decode/accumulate flows and a 6-output instance for range errors.
module tb_decoder_onehot_pipe;

  logic       clk;
  logic       rst_n;

  logic       in_valid, in_ready, out_valid, out_ready, err, acc_full;
  logic [2:0] in_idx;
  logic [1:0] mode;
  logic [7:0] f;

  logic       in_valid6, in_ready6, out_valid6, err6, acc_full6;
  logic [2:0] in_idx6;
  logic [1:0] mode6;
  logic [5:0] f6;

  int checks = 0;
  int errors = 0;

  decoder_onehot_pipe #(.IN_WIDTH(3), .OUT_WIDTH(8)) u_dut8 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_idx   (in_idx),
    .mode     (mode),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .f        (f),
    .err      (err),
    .acc_full (acc_full)
  );

  decoder_onehot_pipe #(.IN_WIDTH(3), .OUT_WIDTH(6)) u_dut6 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid6),
    .in_ready (in_ready6),
    .in_idx   (in_idx6),
    .mode     (mode6),
    .out_valid(out_valid6),
    .out_ready(1'b1),
    .f        (f6),
    .err      (err6),
    .acc_full (acc_full6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int         acc_idx [9];
    logic [7:0] acc_exp [9];
    acc_idx = '{1, 4, 1, 0, 2, 3, 5, 6, 7};
    acc_exp = '{8'h02, 8'h12, 8'h12, 8'h13, 8'h17, 8'h1F, 8'h3F, 8'h7F, 8'hFF};

    rst_n = 1'b0; in_valid = 1'b0; in_idx = '0; mode = 2'b00; out_ready = 1'b1;
    in_valid6 = 1'b0; in_idx6 = '0; mode6 = 2'b00;
    tick(); tick();
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_f",         32'(f),         32'h0);
    chk("rst_err",       32'(err),       32'h0);
    chk("rst_acc_full",  32'(acc_full),  32'h0);
    chk("rst_in_ready",  32'(in_ready),  32'h1);
    rst_n = 1'b1;

    // One-hot stream at full throughput.
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_idx = 3'(i); mode = 2'b00;
      chk("oh_in_ready", 32'(in_ready), 32'h1);
      tick();
      chk("oh_valid", 32'(out_valid), 32'h1);
      chk("oh_f",     32'(f),         32'h1 << i);
      chk("oh_err",   32'(err),       32'h0);
    end

    // Thermometer.
    mode = 2'b01; in_idx = 3'd3; tick();
    chk("th3_f", 32'(f), 32'h0F);
    in_idx = 3'd0; tick();
    chk("th0_f", 32'(f), 32'h01);
    in_idx = 3'd7; tick();
    chk("th7_f",   32'(f),   32'hFF);
    chk("th7_err", 32'(err), 32'h0);

    // Accumulate up to full mask.
    mode = 2'b10;
    for (int i = 0; i < 9; i++) begin
      in_idx = 3'(acc_idx[i]);
      tick();
      chk("acc_f",    32'(f),        32'(acc_exp[i]));
      chk("acc_full", 32'(acc_full), (i == 8) ? 32'h1 : 32'h0);
    end

    // Clear, then mask restarts from zero.
    mode = 2'b11; in_idx = 3'd6; tick();
    chk("clr_f",    32'(f),        32'h00);
    chk("clr_full", 32'(acc_full), 32'h0);
    chk("clr_err",  32'(err),      32'h0);
    mode = 2'b10; in_idx = 3'd2; tick();
    chk("acc2_f", 32'(f), 32'h04);
    // One-hot in between must leave the mask untouched.
    mode = 2'b00; in_idx = 3'd5; tick();
    chk("oh5_f", 32'(f), 32'h20);
    mode = 2'b10; in_idx = 3'd0; tick();
    chk("acc0_f", 32'(f), 32'h05);

    // Drain: valid drops, data holds.
    in_valid = 1'b0; tick();
    chk("drain_valid", 32'(out_valid), 32'h0);
    chk("drain_f",     32'(f),         32'h05);

    // Back-pressure.
    in_valid = 1'b1; mode = 2'b00; in_idx = 3'd3; tick();
    chk("bp_first_f", 32'(f), 32'h08);
    out_ready = 1'b0; in_idx = 3'd5;
    #1;
    chk("bp_in_ready0", 32'(in_ready), 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_hold_f",     32'(f),         32'h08);
      chk("bp_hold_valid", 32'(out_valid), 32'h1);
      chk("bp_in_ready",   32'(in_ready),  32'h0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(in_ready), 32'h1);
    tick();
    chk("bp_next_f",     32'(f),         32'h20);
    chk("bp_next_valid", 32'(out_valid), 32'h1);
    in_valid = 1'b0; tick();
    chk("bp_drain_valid", 32'(out_valid), 32'h0);

    // Reset mid-stream with a stalled result and acc = 0x12.
    in_valid = 1'b1; mode = 2'b11; tick();
    mode = 2'b10; in_idx = 3'd1; tick();
    in_idx = 3'd4; tick();
    chk("mid_acc_f", 32'(f), 32'h12);
    in_valid = 1'b0; out_ready = 1'b0; rst_n = 1'b0; tick();
    chk("mid_rst_valid", 32'(out_valid), 32'h0);
    chk("mid_rst_f",     32'(f),         32'h0);
    chk("mid_rst_full",  32'(acc_full),  32'h0);
    rst_n = 1'b1; out_ready = 1'b1; in_valid = 1'b1; mode = 2'b10; in_idx = 3'd0; tick();
    chk("mid_acc0_f", 32'(f), 32'h01);
    in_valid = 1'b0; tick();

    // Out-of-range indices on the 6-output instance.
    in_valid6 = 1'b1;
    mode6 = 2'b01; in_idx6 = 3'd7; tick();
    chk("w6_th7_f",   32'(f6),   32'h3F);
    chk("w6_th7_err", 32'(err6), 32'h1);
    mode6 = 2'b00; tick();
    chk("w6_oh7_f",   32'(f6),   32'h00);
    chk("w6_oh7_err", 32'(err6), 32'h1);
    in_idx6 = 3'd5; tick();
    chk("w6_oh5_f",   32'(f6),   32'h20);
    chk("w6_oh5_err", 32'(err6), 32'h0);
    mode6 = 2'b10; in_idx6 = 3'd2; tick();
    chk("w6_acc2_f", 32'(f6), 32'h04);
    in_idx6 = 3'd6; tick();
    chk("w6_acc6_f",   32'(f6),   32'h04);
    chk("w6_acc6_err", 32'(err6), 32'h1);
    mode6 = 2'b11; tick();
    chk("w6_clr_f",   32'(f6),   32'h00);
    chk("w6_clr_err", 32'(err6), 32'h0);
    in_valid6 = 1'b0; tick();
    chk("w6_idle_valid", 32'(out_valid6), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
